joy_pad: RTL and testbench

Device-side emulator of a Sega-style 3/6-button gamepad for the 9-pin joystick port. It drives the pad data lines from an internal button word, sequenced by the host's select line. It is the counterpart of the host-side pad reader, so the console core, or an external console, can be fed by keyboard or other input sources. Button bit order matches the reader's `joy[11:0]` word.

---
 rtl/joy_pad.sv | 120 ++++++++++++
 tb/tb_joy_pad.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_pad.sv
// Device-side Sega 3/6-button pad emulator: a select-edge phase counter picks
// which button group is driven onto the active-low pad data lines.
//
// phase | meaning
// 0     | idle high      (U D L R B C)
// 1     | low #1         (U D 0 0 A ST)
// 2     | high #2        (U D L R B C)
// 3     | low #2         (U D 0 0 A ST)
// 4     | high #3        (U D L R B C)
// 5     | low #3         (0 0 0 0 A ST, 6-button ident)
// 6     | high #4        (Z Y X M B C)
// 7     | low #4         (1 1 1 1 A ST)
module joy_pad #(
  parameter int unsigned TIMEOUT    = 2500,
  parameter bit          SIX_BUTTON = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] btn,
  input  logic        pin_d7,
  output logic        pin_d1,
  output logic        pin_d2,
  output logic        pin_d3,
  output logic        pin_d4,
  output logic        pin_d6,
  output logic        pin_d9,
  output logic [2:0]  phase
);

  localparam int BIT_B  = 0;
  localparam int BIT_A  = 1;
  localparam int BIT_ST = 2;
  localparam int BIT_U  = 3;
  localparam int BIT_D  = 4;
  localparam int BIT_L  = 5;
  localparam int BIT_R  = 6;
  localparam int BIT_C  = 7;
  localparam int BIT_M  = 8;
  localparam int BIT_Z  = 9;
  localparam int BIT_Y  = 10;
  localparam int BIT_X  = 11;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic        sel_m_q, sel_s_q, sel_d_q;
  logic [2:0]  phase_q, phase_d;
  logic [15:0] tmo_q, tmo_d;
  logic [5:0]  pins_q, pins_d;   // {d9, d6, d4, d3, d2, d1}
  logic [2:0]  ph_eff;
  logic        sel_edge;

  assign sel_edge = (sel_s_q != sel_d_q);

  // An edge beats the timeout; a saturated timeout realigns phase parity to the line.
  always_comb begin
    phase_d = phase_q;
    tmo_d   = tmo_q;
    if (sel_edge) begin
      phase_d = phase_q + 3'd1;
      tmo_d   = 16'd0;
    end else if (tmo_q == TMO_LAST) begin
      phase_d = {2'b00, ~sel_s_q};
    end else begin
      tmo_d   = tmo_q + 16'd1;
    end
  end

  always_comb begin
    ph_eff = phase_q;
    if (!SIX_BUTTON) begin
      if (phase_q == 3'd6)
        ph_eff = 3'd0;
      else if (phase_q == 3'd5 || phase_q == 3'd7)
        ph_eff = 3'd1;
    end
  end

  always_comb begin
    pins_d = 6'b111111;
    case (ph_eff)
      3'd0, 3'd2, 3'd4:
        pins_d = {~btn[BIT_C], ~btn[BIT_B], ~btn[BIT_R], ~btn[BIT_L], ~btn[BIT_D], ~btn[BIT_U]};
      3'd6:
        pins_d = {~btn[BIT_C], ~btn[BIT_B], ~btn[BIT_M], ~btn[BIT_X], ~btn[BIT_Y], ~btn[BIT_Z]};
      3'd1, 3'd3:
        pins_d = {~btn[BIT_ST], ~btn[BIT_A], 1'b0, 1'b0, ~btn[BIT_D], ~btn[BIT_U]};
      3'd5:
        pins_d = {~btn[BIT_ST], ~btn[BIT_A], 4'b0000};
      default:
        pins_d = {~btn[BIT_ST], ~btn[BIT_A], 4'b1111};
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_m_q <= 1'b1;
      sel_s_q <= 1'b1;
      sel_d_q <= 1'b1;
      phase_q <= 3'd0;
      tmo_q   <= 16'd0;
      pins_q  <= 6'b111111;
    end else begin
      sel_m_q <= pin_d7;
      sel_s_q <= sel_m_q;
      sel_d_q <= sel_s_q;
      phase_q <= phase_d;
      tmo_q   <= tmo_d;
      pins_q  <= pins_d;
    end
  end

  assign pin_d1 = pins_q[0];
  assign pin_d2 = pins_q[1];
  assign pin_d3 = pins_q[2];
  assign pin_d4 = pins_q[3];
  assign pin_d6 = pins_q[4];
  assign pin_d9 = pins_q[5];
  assign phase  = phase_q;

endmodule

// File: tb/tb_joy_pad.sv
// Directed bench for joy_pad: a 6-button and a 3-button instance share the
// host side; expected pin maps are hand-computed per phase.
module tb_joy_pad;

  localparam int TMO = 2500;
  localparam int GAP = 500;

  localparam int B_ = 0, A_ = 1, ST_ = 2, U_ = 3, D_ = 4, L_ = 5, R_ = 6;
  localparam int C_ = 7, M_ = 8, Z_ = 9, Y_ = 10, X_ = 11;

  logic        clock;
  logic        reset_n;
  logic [11:0] btn;
  logic        pin_d7;

  logic s_d1, s_d2, s_d3, s_d4, s_d6, s_d9;
  logic t_d1, t_d2, t_d3, t_d4, t_d6, t_d9;
  logic [2:0] s_phase, t_phase;
  logic [5:0] pins6, pins3;

  assign pins6 = {s_d9, s_d6, s_d4, s_d3, s_d2, s_d1};
  assign pins3 = {t_d9, t_d6, t_d4, t_d3, t_d2, t_d1};

  joy_pad #(.TIMEOUT(TMO), .SIX_BUTTON(1'b1)) u_six (
    .clock(clock), .reset_n(reset_n), .btn(btn), .pin_d7(pin_d7),
    .pin_d1(s_d1), .pin_d2(s_d2), .pin_d3(s_d3), .pin_d4(s_d4),
    .pin_d6(s_d6), .pin_d9(s_d9), .phase(s_phase)
  );

  joy_pad #(.TIMEOUT(TMO), .SIX_BUTTON(1'b0)) u_three (
    .clock(clock), .reset_n(reset_n), .btn(btn), .pin_d7(pin_d7),
    .pin_d1(t_d1), .pin_d2(t_d2), .pin_d3(t_d3), .pin_d4(t_d4),
    .pin_d6(t_d6), .pin_d9(t_d9), .phase(t_phase)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // pins packed as {d9, d6, d4, d3, d2, d1}
  typedef struct packed {
    logic [11:0] b;
    logic [2:0]  ph;
    logic [5:0]  exp6;
    logic [5:0]  exp3;
  } vec_t;

  vec_t vecs[24];
  logic [11:0] asm_w;

  initial begin
    // frame 1: X, U, A pressed
    vecs[0]  = '{12'h80A, 3'd0, 6'b111110, 6'b111110};
    vecs[1]  = '{12'h80A, 3'd1, 6'b100010, 6'b100010};
    vecs[2]  = '{12'h80A, 3'd2, 6'b111110, 6'b111110};
    vecs[3]  = '{12'h80A, 3'd3, 6'b100010, 6'b100010};
    vecs[4]  = '{12'h80A, 3'd4, 6'b111110, 6'b111110};
    vecs[5]  = '{12'h80A, 3'd5, 6'b100000, 6'b100010};
    vecs[6]  = '{12'h80A, 3'd6, 6'b111011, 6'b111110};
    vecs[7]  = '{12'h80A, 3'd7, 6'b101111, 6'b100010};
    // frame 2: Z, M, C, L, ST, B pressed
    vecs[8]  = '{12'h3A5, 3'd0, 6'b001011, 6'b001011};
    vecs[9]  = '{12'h3A5, 3'd1, 6'b010011, 6'b010011};
    vecs[10] = '{12'h3A5, 3'd2, 6'b001011, 6'b001011};
    vecs[11] = '{12'h3A5, 3'd3, 6'b010011, 6'b010011};
    vecs[12] = '{12'h3A5, 3'd4, 6'b001011, 6'b001011};
    vecs[13] = '{12'h3A5, 3'd5, 6'b010000, 6'b010011};
    vecs[14] = '{12'h3A5, 3'd6, 6'b000110, 6'b001011};
    vecs[15] = '{12'h3A5, 3'd7, 6'b011111, 6'b010011};
    // frame 3: U only
    vecs[16] = '{12'h008, 3'd0, 6'b111110, 6'b111110};
    vecs[17] = '{12'h008, 3'd1, 6'b110010, 6'b110010};
    vecs[18] = '{12'h008, 3'd2, 6'b111110, 6'b111110};
    vecs[19] = '{12'h008, 3'd3, 6'b110010, 6'b110010};
    vecs[20] = '{12'h008, 3'd4, 6'b111110, 6'b111110};
    vecs[21] = '{12'h008, 3'd5, 6'b110000, 6'b110010};
    vecs[22] = '{12'h008, 3'd6, 6'b111111, 6'b111110};
    vecs[23] = '{12'h008, 3'd7, 6'b111111, 6'b110010};

    // reset and quiet line
    reset_n = 1'b0;
    pin_d7  = 1'b1;
    btn     = 12'h000;
    asm_w   = 12'h000;
    #50;
    check("reset_pins6", {6'd0, pins6}, 12'h03F);
    check("reset_phase", {9'd0, s_phase}, 12'h000);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(10);
      check("idle_pins6", {6'd0, pins6}, 12'h03F);
      check("idle_pins3", {6'd0, pins3}, 12'h03F);
      check("idle_phase", {9'd0, s_phase}, 12'h000);
    end

    // host-style frames, one vector per select half-period
    for (int i = 0; i < 24; i++) begin
      pin_d7 = ~vecs[i].ph[0];
      btn    = vecs[i].b;
      step(5);
      check($sformatf("vec%0d_phase6", i), {9'd0, s_phase}, {9'd0, vecs[i].ph});
      check($sformatf("vec%0d_phase3", i), {9'd0, t_phase}, {9'd0, vecs[i].ph});
      check($sformatf("vec%0d_pins6", i), {6'd0, pins6}, {6'd0, vecs[i].exp6});
      check($sformatf("vec%0d_pins3", i), {6'd0, pins3}, {6'd0, vecs[i].exp3});
      case (vecs[i].ph)
        3'd0: begin
          asm_w[U_] = ~s_d1; asm_w[D_] = ~s_d2; asm_w[L_] = ~s_d3;
          asm_w[R_] = ~s_d4; asm_w[B_] = ~s_d6; asm_w[C_] = ~s_d9;
        end
        3'd1: begin
          asm_w[A_] = ~s_d6; asm_w[ST_] = ~s_d9;
        end
        3'd6: begin
          asm_w[Z_] = ~s_d1; asm_w[Y_] = ~s_d2; asm_w[X_] = ~s_d3; asm_w[M_] = ~s_d4;
        end
        3'd7: check($sformatf("vec%0d_assembled", i), asm_w, vecs[i].b);
        default: ;
      endcase
      step(GAP - 5);
    end

    // wrap 7 -> 0, then select latency
    pin_d7 = 1'b1;
    btn    = 12'h80A;
    step(GAP);
    check("wrap_phase", {9'd0, s_phase}, 12'h000);
    pin_d7 = 1'b0;
    step(2);
    check("lat_k1_phase", {9'd0, s_phase}, 12'h000);
    step(1);
    check("lat_k2_phase", {9'd0, s_phase}, 12'h001);
    check("lat_k2_pins", {6'd0, pins6}, 12'h03E);
    step(1);
    check("lat_k3_pins", {6'd0, pins6}, 12'h022);
    step(GAP - 4);

    // stop after 3 edges, then timeout resync
    pin_d7 = 1'b1;
    step(GAP);
    check("edge2_phase", {9'd0, s_phase}, 12'h002);
    pin_d7 = 1'b0;
    step(3);
    check("edge3_phase", {9'd0, s_phase}, 12'h003);
    step(TMO - 1);
    check("tmo_before", {9'd0, s_phase}, 12'h003);
    step(1);
    check("tmo_resync", {9'd0, s_phase}, 12'h001);
    check("tmo_resync3", {9'd0, t_phase}, 12'h001);
    pin_d7 = 1'b1;
    step(3);
    check("post_tmo_rise", {9'd0, s_phase}, 12'h002);
    step(TMO + 5);
    check("idle_tmo_phase", {9'd0, s_phase}, 12'h000);

    // button change latency in phase 0
    btn = 12'h000;
    step(1);
    check("r_start", {11'd0, s_d4}, 12'h001);
    btn = 12'h040;
    check("r_same_cycle", {11'd0, s_d4}, 12'h001);
    step(1);
    check("r_press", {11'd0, s_d4}, 12'h000);
    btn = 12'h000;
    step(1);
    check("r_release", {11'd0, s_d4}, 12'h001);

    // async reset while in phase 6 with all buttons pressed
    btn = 12'hFFF;
    for (int i = 0; i < 6; i++) begin
      pin_d7 = ~pin_d7;
      step(10);
    end
    check("ph6_phase", {9'd0, s_phase}, 12'h006);
    check("ph6_pins", {6'd0, pins6}, 12'h000);
    #5;
    reset_n = 1'b0;
    #1;
    check("rst_pins6", {6'd0, pins6}, 12'h03F);
    check("rst_pins3", {6'd0, pins3}, 12'h03F);
    check("rst_phase", {9'd0, s_phase}, 12'h000);
    step(2);
    reset_n = 1'b1;
    step(5);
    check("rst_release_phase", {9'd0, s_phase}, 12'h000);

    // reset released with select already low
    reset_n = 1'b0;
    pin_d7  = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    check("low_rel_clk2", {9'd0, s_phase}, 12'h000);
    step(1);
    check("low_rel_clk3", {9'd0, s_phase}, 12'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
